// File: rtl/pc_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: selects the next PC
// (sequential, jump, branch, trap), handshakes with imem, supports halt/resume.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] epc,
    output logic [31:0] instret,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] instret_q, instret_d;

    logic [31:0] pc_plus4;
    logic        fetching;
    logic        accepted;

    assign pc_plus4 = pc_q + 32'd4;
    assign fetching = (state_q == FETCH);
    assign accepted = fetching & imem_ready & ~stall;

    assign imem_req  = fetching;
    assign pc_valid  = accepted;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign epc       = epc_q;
    assign instret   = instret_q;
    assign state     = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        instret_d = instret_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (trap) begin
                    // Trap wins even over a stall or memory wait; epc gets the held pc.
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (accepted) begin
                    instret_d = instret_q + 32'd1;
                    if (halt) begin
                        pc_d    = pc_plus4;
                        state_d = HALTED;
                    end else if (jump) begin
                        pc_d = {jump_target[31:2], 2'b00};
                    end else if (branch_taken) begin
                        pc_d = {branch_target[31:2], 2'b00};
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HALTED: begin
                if (trap) begin
                    pc_d    = TRAP_VECTOR;
                    epc_d   = pc_q;
                    state_d = FETCH;
                end else if (resume) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            epc_q     <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter of the unicycle core and sequences instruction fetch. Each cycle it selects the next PC from four sources: sequential +4, branch target, jump target or trap vector. It drives a request/ready handshake toward instruction memory and holds the PC on pipeline stalls. It also implements a halt/resume state and counts retired instructions. It sits between the control unit/ALU branch logic and the instruction memory port.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard stall; hold PC, refetch the same address
- branch_taken  in  1  conditional branch resolved taken for the instruction at pc
- branch_target  in  32  branch destination
- jump  in  1  unconditional jump for the instruction at pc
- jump_target  in  32  jump destination
- trap  in  1  exception/trap request
- halt  in  1  instruction at pc is HALT
- resume  in  1  leave HALTED state
- imem_ready  in  1  instruction memory returns data for imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; always equals pc
- pc  out  32  current program counter
- pc_valid  out  1  instruction at pc accepted this cycle
- epc  out  32  PC saved on the last trap
- instret  out  32  retired-instruction counter
- state  out  2  FSM state: 0 BOOT, 1 FETCH, 2 HALTED

## Operation
- Reset asserted (reset=0), effective immediately: pc=RESET_VECTOR, epc=0, instret=0, state=BOOT. With this state, imem_req=0 and pc_valid=0.
- BOOT: lasts exactly one cycle after reset deasserts. imem_req=0. Unconditionally transitions to FETCH. Trap is ignored in BOOT.
- FETCH:
  - imem_req=1.
  - pc_valid = imem_ready & ~stall, combinational.
  - The next PC is chosen by priority on each edge:
    1. trap: pc=TRAP_VECTOR, epc=pc. Taken even when stall=1 or imem_ready=0.
    2. stall or ~imem_ready: pc holds.
    3. jump: pc = {jump_target[31:2],2'b00}.
    4. branch_taken: pc = {branch_target[31:2],2'b00}.
    5. Otherwise: pc = pc+4.
  - Items 3–5 apply only when pc_valid=1.
  - jump and branch_taken both high: jump wins.
  - halt with pc_valid=1 and no trap: pc=pc+4, state=HALTED. Any jump or branch_taken in the same cycle is ignored.
- HALTED:
  - imem_req=0 and pc_valid=0; pc and instret hold.
  - resume=1 → FETCH on the next edge, pc unchanged.
  - trap=1 → pc=TRAP_VECTOR, epc=pc, state=FETCH. Trap has priority over resume.
- instret increments by 1 on every edge where pc_valid=1 and trap=0. It wraps modulo 2^32.
- Arithmetic:
  - pc+4 is 32-bit modulo: 32'hFFFF_FFFC → 32'h0000_0000.
  - Target bits [1:0] are forced to 0.
  - TRAP_VECTOR and RESET_VECTOR are used as given.

## Timing
- pc, epc, instret and state are registered. imem_addr, imem_req and pc_valid are combinational from the state and inputs.
- First fetch: imem_req rises in the second cycle after reset deasserts (one BOOT cycle).
- Redirect latency: a redirect or increment sampled at edge N is visible on pc/imem_addr after edge N. There are no bubbles.
- Memory wait states: imem_ready=0 for k cycles extends the fetch by k cycles with imem_addr stable.
- Reset mid-operation: an asynchronous return to the reset values regardless of state.
- Trap during stall or a memory wait: taken at the next edge, and epc captures the held pc.

## Test plan
- Reset release with imem_ready=1 held: state BOOT for 1 cycle. Then pc = 0x0, 0x4, 0x8 on consecutive cycles, and instret=3 after the third accepted fetch.
- Redirect priority:
  - pc=0x10, jump=1 with jump_target=0x43 and branch_taken=1 with branch_target=0x80 → pc=0x40.
  - Next cycle, branch_taken=1 with branch_target=0x80 → pc=0x80.
- Stall and wait states at pc=0x20:
  - stall=1 for 2 cycles → pc stays 0x20, pc_valid=0, instret unchanged.
  - imem_ready=0 for 3 cycles → imem_addr=0x20 held.
- Trap under stall: pc=0x30, stall=1, trap=1 → pc=0x100, epc=0x30, instret unchanged.
- Halt/resume:
  - halt at pc=0x44 → state=HALTED, pc=0x48, imem_req=0.
  - resume after 5 idle cycles → FETCH with imem_addr=0x48.
  - Simultaneous trap+resume in HALTED → pc=0x100, epc=0x48.
- Wrap and async reset:
  - jump_target=0xFFFF_FFFC, then one sequential fetch → pc=0x0.
  - Assert reset between clock edges → pc=0x0 and state=BOOT immediately.
